// File: rtl/jtframe_neptuno_joy.sv
// NeptUNO joystick scanner: walks the two-pad shift-register chain in both
// MegaDrive select phases and publishes complete, active-high button bytes.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | wait GAP ticks between scans; holds here while en=0
// SEL   | drive joy_select for the current phase, settle 4 ticks
// LOAD  | joy_load low for one tick to latch the pads
// SHIFT | 16 bits, two ticks each (sample + clk high, then clk low)
// DONE  | merge both phases into joy1/joy2, pulse valid for one clk
module jtframe_neptuno_joy #(
  parameter int DIV = 8,
  parameter int GAP = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       joy_data,
  output logic       joy_clk,
  output logic       joy_load,
  output logic       joy_select,
  output logic [7:0] joy1,
  output logic [7:0] joy2,
  output logic       valid
);

  localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  typedef enum logic [2:0] {IDLE, SEL, LOAD, SHIFT, DONE} state_t;

  state_t         state, state_nxt;
  logic [DW-1:0]  div_cnt;
  logic           tick;
  logic [GW-1:0]  gap_cnt, gap_cnt_nxt;
  logic [1:0]     sel_cnt, sel_cnt_nxt;
  logic [3:0]     bit_cnt, bit_cnt_nxt;
  logic           half, half_nxt;
  logic           phase, phase_nxt;
  logic [15:0]    s, s_nxt;
  logic [15:0]    hold, hold_nxt;
  logic           joy_clk_nxt, joy_load_nxt, joy_select_nxt, valid_nxt;
  logic [7:0]     joy1_nxt, joy2_nxt;

  assign tick = (div_cnt == '0);

  // Free-running down-counter; tick fires on terminal count regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_cnt <= '0;
    else        div_cnt <= tick ? DIV_LAST : div_cnt - 1'b1;
  end

  // Next-state and output decode; every step except DONE waits for tick.
  always_comb begin
    state_nxt      = state;
    gap_cnt_nxt    = gap_cnt;
    sel_cnt_nxt    = sel_cnt;
    bit_cnt_nxt    = bit_cnt;
    half_nxt       = half;
    phase_nxt      = phase;
    s_nxt          = s;
    hold_nxt       = hold;
    joy_clk_nxt    = joy_clk;
    joy_load_nxt   = joy_load;
    joy_select_nxt = joy_select;
    joy1_nxt       = joy1;
    joy2_nxt       = joy2;
    valid_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          if (gap_cnt == GAP_LAST) begin
            // Saturated: a late en starts the scan on the very next tick.
            if (en) begin
              state_nxt   = SEL;
              sel_cnt_nxt = '0;
              phase_nxt   = 1'b0;
            end
          end else begin
            gap_cnt_nxt = gap_cnt + 1'b1;
          end
        end
      end
      SEL: begin
        joy_select_nxt = ~phase;
        if (tick) begin
          if (sel_cnt == 2'd3) begin
            state_nxt    = LOAD;
            joy_load_nxt = 1'b0;
          end else begin
            sel_cnt_nxt = sel_cnt + 1'b1;
          end
        end
      end
      LOAD: begin
        if (tick) begin
          state_nxt    = SHIFT;
          joy_load_nxt = 1'b1;
          bit_cnt_nxt  = 4'd15;
          half_nxt     = 1'b0;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!half) begin
            s_nxt[bit_cnt] = joy_data;
            joy_clk_nxt    = 1'b1;
            half_nxt       = 1'b1;
          end else begin
            joy_clk_nxt = 1'b0;
            half_nxt    = 1'b0;
            if (bit_cnt == 4'd0) begin
              if (!phase) begin
                hold_nxt    = s;
                phase_nxt   = 1'b1;
                sel_cnt_nxt = '0;
                state_nxt   = SEL;
              end else begin
                state_nxt = DONE;
              end
            end else begin
              bit_cnt_nxt = bit_cnt - 1'b1;
            end
          end
        end
      end
      DONE: begin
        // hold = phase 0 (dirs, B, C), s = phase 1 (A, Start); chain is active-low.
        joy1_nxt    = ~{s[10], hold[10], hold[11], s[11],
                        hold[15], hold[14], hold[13], hold[12]};
        joy2_nxt    = ~{s[2], hold[2], hold[3], s[3],
                        hold[7], hold[6], hold[5], hold[4]};
        valid_nxt   = 1'b1;
        gap_cnt_nxt = '0;
        phase_nxt   = 1'b0;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any scan in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      sel_cnt    <= '0;
      bit_cnt    <= '0;
      half       <= 1'b0;
      phase      <= 1'b0;
      s          <= '0;
      hold       <= '0;
      joy_clk    <= 1'b0;
      joy_load   <= 1'b1;
      joy_select <= 1'b1;
      joy1       <= '0;
      joy2       <= '0;
      valid      <= 1'b0;
    end else begin
      state      <= state_nxt;
      gap_cnt    <= gap_cnt_nxt;
      sel_cnt    <= sel_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      half       <= half_nxt;
      phase      <= phase_nxt;
      s          <= s_nxt;
      hold       <= hold_nxt;
      joy_clk    <= joy_clk_nxt;
      joy_load   <= joy_load_nxt;
      joy_select <= joy_select_nxt;
      joy1       <= joy1_nxt;
      joy2       <= joy2_nxt;
      valid      <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_jtframe_neptuno_joy.sv
// Bench for jtframe_neptuno_joy: two MegaDrive pads behind a 16-bit
// parallel-load shift chain, driven from per-player button vectors.
module tb_jtframe_neptuno_joy;

  localparam int DIV    = 8;
  localparam int GAP    = 64;
  localparam int PERIOD = (74 + GAP) * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       joy_data;
  logic       joy_clk, joy_load, joy_select, valid;
  logic [7:0] joy1, joy2;

  int checks = 0;
  int failures = 0;

  jtframe_neptuno_joy #(.DIV(DIV), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .joy_data(joy_data),
    .joy_clk(joy_clk), .joy_load(joy_load), .joy_select(joy_select),
    .joy1(joy1), .joy2(joy2), .valid(valid)
  );

  always #5 clk = ~clk;

  // Pressed buttons per player, {start,C,B,A,up,down,left,right}, plus
  // noise for the positions the scanner must ignore.
  logic [7:0] p1_btn = 8'h00, p2_btn = 8'h00, junk = 8'h00;

  function automatic logic [7:0] pad_byte(input logic sel, input logic [7:0] b, input logic [7:0] j);
    logic [7:0] pr, dc;
    if (sel) begin
      pr = {b[3], b[2], b[1], b[0], b[5], b[6], 2'b00};
      dc = 8'b0000_0011;
    end else begin
      pr = {4'b0000, b[4], b[7], 2'b00};
      dc = 8'b1111_0011;  // phase-1 up/down are ignored too
    end
    return (pr & ~dc) | (j & dc);
  endfunction

  function automatic logic [15:0] make_word(input logic sel, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] j);
    return ~{pad_byte(sel, b1, j), pad_byte(sel, b2, ~j)};
  endfunction

  // Chain model: load while joy_load is low, shift MSB-first on joy_clk rise.
  logic [15:0] sr = 16'hffff;
  logic        clk_q = 1'b0;
  assign joy_data = sr[15];
  always @(negedge clk) begin
    if (!joy_load) sr <= make_word(joy_select, p1_btn, p2_btn, junk);
    else if (joy_clk && !clk_q) sr <= {sr[14:0], 1'b1};
    clk_q <= joy_clk;
  end

  // Waveform monitor.
  int         load_falls = 0, clk_rises = 0, viol = 0, lw = 0;
  logic [7:0] load_idx = 8'd0;
  logic       sel_hist [256];
  int         width_hist [256];
  logic       pl = 1'b1, pc = 1'b0;
  always @(negedge clk) begin
    if (joy_clk && !joy_load) viol <= viol + 1;
    if (!joy_load && pl) begin
      sel_hist[load_idx] <= joy_select;
      load_idx   <= load_idx + 8'd1;
      load_falls <= load_falls + 1;
      lw <= 1;
    end else if (!joy_load) begin
      lw <= lw + 1;
    end
    if (joy_load && !pl) width_hist[load_idx - 8'd1] <= lw;
    if (joy_clk && !pc) clk_rises <= clk_rises + 1;
    pl <= joy_load;
    pc <= joy_clk;
  end

  task automatic wait_valid(input int limit, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < limit && !ok) begin
      @(negedge clk);
      n++;
      if (valid) ok = 1'b1;
    end
  endtask

  task automatic wait_load(input logic sel, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 2 * PERIOD && !ok) begin
      @(negedge clk);
      n++;
      if (!joy_load && joy_select == sel) ok = 1'b1;
    end
  endtask

  task automatic wait_rises(input int want, output bit ok);
    int n = 0, got = 0;
    logic prev;
    prev = joy_clk;
    while (n < PERIOD && got < want) begin
      @(negedge clk);
      n++;
      if (joy_clk && !prev) got++;
      prev = joy_clk;
    end
    ok = (got == want);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 6;
    if (joy_clk !== 1'b0)    begin failures++; $display("FAIL reset_joy_clk: got %b expected 0", joy_clk); end
    if (joy_load !== 1'b1)   begin failures++; $display("FAIL reset_joy_load: got %b expected 1", joy_load); end
    if (joy_select !== 1'b1) begin failures++; $display("FAIL reset_joy_select: got %b expected 1", joy_select); end
    if (joy1 !== 8'h00)      begin failures++; $display("FAIL reset_joy1: got %h expected 00", joy1); end
    if (joy2 !== 8'h00)      begin failures++; $display("FAIL reset_joy2: got %h expected 00", joy2); end
    if (valid !== 1'b0)      begin failures++; $display("FAIL reset_valid: got %b expected 0", valid); end
  endtask

  // Released pads; first valid GAP+74 ticks after reset, then one per period.
  task automatic test_idle_data;
    int n;
    bit ok;
    p1_btn = 8'h00; p2_btn = 8'h00; junk = 8'h00;
    rst_n = 1'b1;
    wait_valid(2 * PERIOD, n, ok);
    checks++;
    if (!ok || n <= (GAP + 73) * DIV || n > (GAP + 74) * DIV) begin
      failures++; $display("FAIL first_valid_latency: got %0d clk (seen=%0b) expected %0d..%0d", n, ok, (GAP + 73) * DIV + 1, (GAP + 74) * DIV);
    end
    checks += 2;
    if (joy1 !== 8'h00) begin failures++; $display("FAIL idle_joy1: got %h expected 00", joy1); end
    if (joy2 !== 8'h00) begin failures++; $display("FAIL idle_joy2: got %h expected 00", joy2); end
    wait_valid(2 * PERIOD, n, ok);
    checks++;
    if (!ok || n != PERIOD) begin failures++; $display("FAIL valid_period: got %0d clk expected %0d", n, PERIOD); end
  endtask

  task automatic test_known;
    int n;
    bit ok;
    p1_btn = 8'h01; p2_btn = 8'h80; junk = 8'h00;
    wait_valid(2 * PERIOD, n, ok);
    checks += 2;
    if (!ok || joy1 !== 8'h01) begin failures++; $display("FAIL known_joy1: got %h expected 01", joy1); end
    if (!ok || joy2 !== 8'h80) begin failures++; $display("FAIL known_joy2: got %h expected 80", joy2); end
  endtask

  task automatic test_waveform;
    int n, lf, cr, vi;
    bit ok;
    logic [7:0] idx;
    lf = load_falls; cr = clk_rises; vi = viol; idx = load_idx;
    wait_valid(2 * PERIOD, n, ok);
    checks += 7;
    if (load_falls - lf != 2) begin failures++; $display("FAIL load_count: got %0d expected 2", load_falls - lf); end
    if (clk_rises - cr != 32) begin failures++; $display("FAIL clk_rises: got %0d expected 32", clk_rises - cr); end
    if (viol != vi) begin failures++; $display("FAIL clk_during_load: got %0d clk expected 0", viol - vi); end
    if (sel_hist[idx] !== 1'b1) begin failures++; $display("FAIL load0_select: got %b expected 1", sel_hist[idx]); end
    if (sel_hist[idx + 8'd1] !== 1'b0) begin failures++; $display("FAIL load1_select: got %b expected 0", sel_hist[idx + 8'd1]); end
    if (width_hist[idx] != DIV) begin failures++; $display("FAIL load0_width: got %0d expected %0d", width_hist[idx], DIV); end
    if (width_hist[idx + 8'd1] != DIV) begin failures++; $display("FAIL load1_width: got %0d expected %0d", width_hist[idx + 8'd1], DIV); end
  endtask

  task automatic test_random;
    int n;
    bit ok;
    for (int i = 0; i < 5; i++) begin
      p1_btn = 8'($urandom); p2_btn = 8'($urandom); junk = 8'($urandom);
      wait_valid(2 * PERIOD, n, ok);
      checks += 2;
      if (!ok || joy1 !== p1_btn) begin failures++; $display("FAIL random_joy1[%0d]: got %h expected %h", i, joy1, p1_btn); end
      if (!ok || joy2 !== p2_btn) begin failures++; $display("FAIL random_joy2[%0d]: got %h expected %h", i, joy2, p2_btn); end
    end
  endtask

  task automatic test_en_drop;
    int n, vcount, lcount;
    bit ok;
    p1_btn = 8'($urandom); p2_btn = 8'($urandom); junk = 8'($urandom);
    wait_load(1'b0, ok);
    if (ok) wait_rises(11, ok);  // bit 5 of phase 1 has just been sampled
    en = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL en_drop_reach_bit5: got timeout expected phase-1 bit 5"); end
    wait_valid(PERIOD, n, ok);
    checks += 2;
    if (!ok) begin failures++; $display("FAIL en_drop_valid: got no valid expected one"); end
    if (joy1 !== p1_btn || joy2 !== p2_btn) begin
      failures++; $display("FAIL en_drop_data: got %h/%h expected %h/%h", joy1, joy2, p1_btn, p2_btn);
    end
    vcount = 0; lcount = 0;
    repeat (2 * PERIOD) begin
      @(negedge clk);
      if (valid) vcount++;
      if (!joy_load) lcount++;
    end
    checks += 2;
    if (vcount != 0) begin failures++; $display("FAIL en_low_valid: got %0d expected 0", vcount); end
    if (lcount != 0) begin failures++; $display("FAIL en_low_load: got %0d clk expected 0", lcount); end
    en = 1'b1;
    n = 0;
    while (n < 2 * PERIOD && joy_load) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n <= 4 * DIV || n > 5 * DIV) begin
      failures++; $display("FAIL en_restart_latency: got %0d clk expected %0d..%0d", n, 4 * DIV + 1, 5 * DIV);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    bit ok;
    p1_btn = 8'h10; p2_btn = 8'($urandom); junk = 8'($urandom);
    wait_valid(2 * PERIOD, n, ok);
    wait_valid(2 * PERIOD, n, ok);
    checks++;
    if (!ok || joy1 !== 8'h10) begin failures++; $display("FAIL pre_reset_joy1: got %h expected 10", joy1); end
    wait_load(1'b1, ok);
    if (ok) wait_rises(5, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL reach_phase0_shift: got timeout expected shift"); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 6;
    if (joy_clk !== 1'b0)    begin failures++; $display("FAIL mid_reset_joy_clk: got %b expected 0", joy_clk); end
    if (joy_load !== 1'b1)   begin failures++; $display("FAIL mid_reset_joy_load: got %b expected 1", joy_load); end
    if (joy_select !== 1'b1) begin failures++; $display("FAIL mid_reset_joy_select: got %b expected 1", joy_select); end
    if (joy1 !== 8'h00)      begin failures++; $display("FAIL mid_reset_joy1: got %h expected 00", joy1); end
    if (joy2 !== 8'h00)      begin failures++; $display("FAIL mid_reset_joy2: got %h expected 00", joy2); end
    if (valid !== 1'b0)      begin failures++; $display("FAIL mid_reset_valid: got %b expected 0", valid); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(2 * PERIOD, n, ok);
    checks += 2;
    if (!ok || n <= (GAP + 73) * DIV || n > (GAP + 74) * DIV) begin
      failures++; $display("FAIL post_reset_latency: got %0d clk (seen=%0b) expected %0d..%0d", n, ok, (GAP + 73) * DIV + 1, (GAP + 74) * DIV);
    end
    if (joy1 !== 8'h10 || joy2 !== p2_btn) begin
      failures++; $display("FAIL post_reset_data: got %h/%h expected 10/%h", joy1, joy2, p2_btn);
    end
  endtask

  initial begin
    test_reset;
    test_idle_data;
    test_known;
    test_waveform;
    test_random;
    test_en_drop;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtframe_neptuno_joy.md
JTFRAME_NEPTUNO_JOY -- requirements
Module: jtframe_neptuno_joy

Interface
REQ-001 Parameter DIV, default 8: clk cycles per tick (legal DIV >= 2).
REQ-002 Parameter GAP, default 64: idle ticks between scans.
REQ-003 clk  in  1  system clock; all logic on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 en  in  1  scan enable; level-sensitive.
REQ-006 joy_data  in  1  serial data from the NeptUNO shift-register chain, active-low buttons.
REQ-007 joy_clk  out  1  shift clock to the chain.
REQ-008 joy_load  out  1  parallel-load strobe, active-low.
REQ-009 joy_select  out  1  MegaDrive pad select line.
REQ-010 joy1  out  8  player-1 buttons, active-high, {start,C,B,A,up,down,left,right}.
REQ-011 joy2  out  8  player-2 buttons, same bit order as joy1.
REQ-012 valid  out  1  one-clk pulse when joy1/joy2 are updated.

Function
REQ-013 Tick prescaler SHALL assert a one-cycle tick every DIV clk cycles; all FSM advances occur only on tick.
REQ-014 The prescaler SHALL run continuously, with no gating by en.
REQ-015 FSM states SHALL be IDLE, SEL, LOAD, SHIFT, DONE.
REQ-016 IDLE: count GAP ticks, then go to SEL with phase=0 if en=1; if en=0, hold IDLE with the counter saturated.
REQ-017 SEL: drive joy_select=~phase (phase0 -> 1, phase1 -> 0), hold 4 ticks, then go to LOAD.
REQ-018 LOAD: joy_load=0 for exactly 1 tick, then joy_load=1 and go to SHIFT with bit counter=15.
REQ-019 SHIFT: 2 ticks per bit.
  - First tick: sample joy_data into s[cnt] and set joy_clk=1.
  - Second tick: set joy_clk=0 and decrement cnt.
  - Exit after bit 0 is sampled.
REQ-020 Per phase: s[15:8] belongs to player 1 and s[7:0] to player 2.
  - Byte bits 7..0 in phase 0 (select high): {U,D,L,R,B,C,x,x}.
  - Byte bits 7..0 in phase 1 (select low): {U,D,x,x,A,Start,x,x}.
REQ-021 After phase 0, the FSM SHALL store s to a holding register, set phase=1 and return to SEL.
REQ-022 After phase 1, go to DONE.
REQ-023 DONE: load joy1/joy2 from both phases, inverting polarity.
  - Directions are taken from phase 0.
  - A and Start are taken from phase 1.
  - B and C are taken from phase 0.
REQ-024 DONE: assert valid for exactly one clk, then go to IDLE with the gap counter cleared.
REQ-025 joy1/joy2 SHALL change only in DONE, never with partial scan data.
REQ-026 A full scan SHALL take 2*(4+1+32) = 74 ticks plus GAP idle ticks.
REQ-027 If en deasserts mid-scan, the current scan SHALL complete including valid; IDLE then holds.
REQ-028 If en reasserts while in IDLE with the gap expired, SEL SHALL be entered on the next tick.
REQ-029 joy_clk SHALL be 0 whenever joy_load=0.
REQ-030 joy_load SHALL be 1 outside the LOAD state.
REQ-031 joy_select SHALL be stable throughout LOAD and SHIFT.

Reset
REQ-032 On rst_n=0, asynchronously:
  - joy_clk=0, joy_load=1, joy_select=1.
  - joy1=joy2=0, valid=0.
  - FSM=IDLE, phase=0, all counters=0.
REQ-033 Reset asserted mid-scan SHALL abort the scan with no valid pulse; joy1/joy2 are cleared.
REQ-034 After rst_n rises, the first SEL SHALL occur after GAP ticks, provided en=1.

Verification
REQ-035 DIV=8, GAP=64, en=1, joy_data tied 1 -> valid every (74+64)*8 = 1104 clk; joy1=joy2=8'h00.
REQ-036 Bench model of the chain: P1 right pressed in phase 0 (s[12]=0), P2 Start pressed in phase 1 (s[2]=0), all else 1 -> joy1=8'h01, joy2=8'h80.
REQ-037 Waveform check over one scan:
  - exactly 2 joy_load pulses, each 1 tick wide;
  - 32 joy_clk rising edges total;
  - joy_select=1 for the first load and 0 for the second;
  - joy_clk=0 whenever joy_load=0.
REQ-038 en dropped at bit 5 of phase 1 -> scan finishes, valid pulses once, no further joy_load while en=0; en back to 1 -> SEL on the next tick.
REQ-039 rst_n pulsed low during SHIFT of phase 0 with joy1 previously 8'h10:
  - outputs return to their reset values immediately;
  - no valid pulse;
  - next valid occurs GAP+74 ticks after rst_n release.
